// File: rtl/welch_seg_scheduler.sv
// welch_seg_scheduler
//   Reads the IQ capture buffer out as overlapping segments for the Welch PSD
//   engine. After a completed capture it walks the buffer in segments of
//   seg_len samples whose starts are hop samples apart. Each segment waits for
//   psd_ready and then streams without stalls.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | disarmed, nothing in flight
//   WAIT_CAP | armed, waiting for capture_done (config latched on it)
//   CHECK    | decide whether another segment fits, else end the frame
//   WAIT_PSD | next segment pending until the PSD engine is ready
//   READ     | streaming the remaining samples of the current segment
//   DONE     | one-cycle frame_done, then back to WAIT_CAP or IDLE
//
// Ports
//   clk, resetn            clock, asynchronous active-low reset
//   arm                    level enable for frame processing
//   capture_done           capture buffer filled (config sampled with it)
//   capture_len            valid samples in the buffer
//   seg_len, hop           segment length and start-to-start step
//   num_avg                max segments per frame, 0 = unlimited
//   psd_ready              PSD engine can take a new segment
//   rd_addr, rd_en         capture memory read port
//   seg_start              first read of a segment
//   sample_valid, seg_last read data qualifier and last-sample flag (rd_en + 1)
//   frame_done             end-of-frame pulse
//   busy                   not IDLE
//   seg_count              segments issued in the current/last frame
//   overrun_cnt            captures dropped while a frame was in progress
//
// Build option: define WELCH_SEG_OVERRUN_EN to build the overrun counter;
// otherwise overrun_cnt is tied to zero.

module welch_seg_scheduler #(
    parameter int ADDR_W = 14,
    parameter int SEG_W  = 12,
    parameter int AVG_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              arm,
    input  logic              capture_done,
    input  logic [ADDR_W-1:0] capture_len,
    input  logic [SEG_W-1:0]  seg_len,
    input  logic [SEG_W-1:0]  hop,
    input  logic [AVG_W-1:0]  num_avg,
    input  logic              psd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    output logic              seg_start,
    output logic              sample_valid,
    output logic              seg_last,
    output logic              frame_done,
    output logic              busy,
    output logic [AVG_W-1:0]  seg_count,
    output logic [15:0]       overrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_CAP, S_CHECK, S_WAIT_PSD, S_READ, S_DONE
    } state_t;

    localparam logic [SEG_W-1:0] SEG_ONE = SEG_W'(1);
    localparam logic [SEG_W-1:0] SEG_TWO = SEG_W'(2);
    localparam logic [AVG_W-1:0] AVG_ONE = AVG_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cfg_len;
    logic [SEG_W-1:0]  cfg_seg;
    logic [SEG_W-1:0]  cfg_hop;
    logic [AVG_W-1:0]  cfg_avg;
    logic [ADDR_W-1:0] base;
    logic [SEG_W-1:0]  idx;
    logic [AVG_W-1:0]  seg_cnt;
    logic [ADDR_W-1:0] addr_hold;

    logic              rd_en_c;
    logic              seg_start_c;
    logic [ADDR_W-1:0] addr_c;
    logic              cfg_bad;
    logic              no_room;
    logic              avg_hit;
    logic              last_beat;
    logic [ADDR_W:0]   seg_end;

    // Segment end is formed one bit wider so a large base+seg_len cannot wrap
    // back into the buffer and look valid.
    assign seg_end   = {1'b0, base} + {{(ADDR_W+1-SEG_W){1'b0}}, cfg_seg};
    assign no_room   = seg_end > {1'b0, cfg_len};
    assign cfg_bad   = (cfg_seg < SEG_TWO) || (cfg_hop == '0) || (cfg_hop > cfg_seg);
    assign avg_hit   = (cfg_avg != '0) && (seg_cnt == cfg_avg);
    assign last_beat = (idx == cfg_seg - SEG_ONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The first read of a segment is issued in the WAIT_PSD accept cycle, so
    // rd_en/seg_start/rd_addr depend on psd_ready there.
    always_comb begin
        state_nxt   = state;
        rd_en_c     = 1'b0;
        seg_start_c = 1'b0;
        addr_c      = addr_hold;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_WAIT_CAP;
            end
            S_WAIT_CAP: begin
                if (!arm)              state_nxt = S_IDLE;
                else if (capture_done) state_nxt = S_CHECK;
            end
            S_CHECK: begin
                if (!arm || cfg_bad || no_room || avg_hit) state_nxt = S_DONE;
                else                                       state_nxt = S_WAIT_PSD;
            end
            S_WAIT_PSD: begin
                if (psd_ready) begin
                    rd_en_c     = 1'b1;
                    seg_start_c = 1'b1;
                    addr_c      = base;
                    state_nxt   = S_READ;
                end
            end
            S_READ: begin
                rd_en_c = 1'b1;
                addr_c  = base + {{(ADDR_W-SEG_W){1'b0}}, idx};
                if (last_beat) state_nxt = S_CHECK;
            end
            S_DONE: begin
                state_nxt = arm ? S_WAIT_CAP : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_len      <= '0;
            cfg_seg      <= '0;
            cfg_hop      <= '0;
            cfg_avg      <= '0;
            base         <= '0;
            idx          <= '0;
            seg_cnt      <= '0;
            addr_hold    <= '0;
            sample_valid <= 1'b0;
            seg_last     <= 1'b0;
        end else begin
            if (state == S_WAIT_CAP && arm && capture_done) begin
                cfg_len <= capture_len;
                cfg_seg <= seg_len;
                cfg_hop <= hop;
                cfg_avg <= num_avg;
                base    <= '0;
                seg_cnt <= '0;
            end
            if (state == S_WAIT_PSD && psd_ready) begin
                idx <= SEG_ONE;
            end
            if (state == S_READ) begin
                idx <= idx + SEG_ONE;
                if (last_beat) begin
                    base <= base + {{(ADDR_W-SEG_W){1'b0}}, cfg_hop};
                    if (seg_cnt != '1) seg_cnt <= seg_cnt + AVG_ONE;
                end
            end
            if (rd_en_c) begin
                addr_hold <= addr_c;
            end
            sample_valid <= rd_en_c;
            seg_last     <= (state == S_READ) && last_beat;
        end
    end

    assign rd_addr    = addr_c;
    assign rd_en      = rd_en_c;
    assign seg_start  = seg_start_c;
    assign frame_done = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign seg_count  = seg_cnt;

`ifdef WELCH_SEG_OVERRUN_EN
    logic [15:0] ovr_cnt;
    logic        in_frame;

    assign in_frame = (state == S_CHECK) || (state == S_WAIT_PSD) ||
                      (state == S_READ)  || (state == S_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovr_cnt <= '0;
        end else if (capture_done && in_frame && ovr_cnt != 16'hFFFF) begin
            ovr_cnt <= ovr_cnt + 16'd1;
        end
    end

    assign overrun_cnt = ovr_cnt;
`else
    assign overrun_cnt = 16'd0;
`endif

endmodule
